window3x3_gen: RTL and testbench

//  Streaming 3x3 neighbourhood generator for RGB565 camera pixels. It accepts one raster-order pixel
//  per qualified cycle and buffers the two previous lines. It drives the nine PixelData_rc inputs of
//  the 3x3 median filter plus a valid strobe and centre coordinates. It sits between the

---
 rtl/vga_img_pkg.sv | 17 +
 rtl/line_buffer.sv | 26 ++
 rtl/window3x3_gen.sv | 122 ++++++++++++
 tb/tb_window3x3_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_img_pkg.sv
// rtl/vga_img_pkg.sv - RGB565 pixel fields and default raster geometry
package vga_img_pkg;

    localparam int H_ACT_DEF = 320;
    localparam int V_ACT_DEF = 240;
    localparam int PIX_W     = 16;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef logic [PIX_W-1:0] pix565_t;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one raster line of pixels, async read, sync write
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read and write share the address; the read returns the old word on the write edge.
    assign rd_data = mem[addr];

    // Storage is deliberately not reset; downstream gating keeps stale words from escaping.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window3x3_gen.sv
// rtl/window3x3_gen.sv - streaming 3x3 neighbourhood generator for the median filter
module window3x3_gen
    import vga_img_pkg::*;
#(
    parameter int H_ACT  = H_ACT_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int DATA_W = PIX_W,
    parameter int XW     = $clog2(H_ACT),
    parameter int YW     = $clog2(V_ACT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] PixelData_00,
    output logic [DATA_W-1:0] PixelData_01,
    output logic [DATA_W-1:0] PixelData_02,
    output logic [DATA_W-1:0] PixelData_10,
    output logic [DATA_W-1:0] PixelData_11,
    output logic [DATA_W-1:0] PixelData_12,
    output logic [DATA_W-1:0] PixelData_20,
    output logic [DATA_W-1:0] PixelData_21,
    output logic [DATA_W-1:0] PixelData_22,
    output logic              win_valid,
    output logic [XW-1:0]     win_cx,
    output logic [YW-1:0]     win_cy
);

    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [XW-1:0]     cur_x;
    logic [YW-1:0]     cur_y;
    logic [DATA_W-1:0] lb0_q;
    logic [DATA_W-1:0] lb1_q;

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign cur_x = in_sof ? '0 : x_cnt;
    assign cur_y = in_sof ? '0 : y_cnt;

    // lb0 holds line y-1; its outgoing word shifts into lb1, which then holds line y-2.
    line_buffer #(
        .DEPTH (H_ACT),
        .WIDTH (DATA_W),
        .AW    (XW)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (in_valid),
        .addr    (cur_x),
        .wr_data (in_data),
        .rd_data (lb0_q)
    );

    line_buffer #(
        .DEPTH (H_ACT),
        .WIDTH (DATA_W),
        .AW    (XW)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (in_valid),
        .addr    (cur_x),
        .wr_data (lb0_q),
        .rd_data (lb1_q)
    );

    // Raster position of the next pixel: x wraps into y, y wraps into the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (in_valid) begin
            if (cur_x == XW'(H_ACT - 1)) begin
                x_cnt <= '0;
                y_cnt <= (cur_y == YW'(V_ACT - 1)) ? '0 : cur_y + YW'(1);
            end else begin
                x_cnt <= cur_x + XW'(1);
                y_cnt <= cur_y;
            end
        end
    end

    // Three-column shift window; column 2 is the freshly read column plus the new pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PixelData_00 <= '0;
            PixelData_01 <= '0;
            PixelData_02 <= '0;
            PixelData_10 <= '0;
            PixelData_11 <= '0;
            PixelData_12 <= '0;
            PixelData_20 <= '0;
            PixelData_21 <= '0;
            PixelData_22 <= '0;
        end else if (in_valid) begin
            PixelData_00 <= PixelData_01;
            PixelData_01 <= PixelData_02;
            PixelData_02 <= lb1_q;
            PixelData_10 <= PixelData_11;
            PixelData_11 <= PixelData_12;
            PixelData_12 <= lb0_q;
            PixelData_20 <= PixelData_21;
            PixelData_21 <= PixelData_22;
            PixelData_22 <= in_data;
        end
    end

    // Strobe only when all three columns and rows belong to the current line and frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_valid <= 1'b0;
            win_cx    <= '0;
            win_cy    <= '0;
        end else begin
            win_valid <= in_valid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
            if (in_valid) begin
                win_cx <= cur_x - XW'(1);
                win_cy <= cur_y - YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// tb/tb_window3x3_gen.sv - scoreboard bench for window3x3_gen against a column-history model
module tb_window3x3_gen;

    localparam int H = 8;
    localparam int V = 6;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [15:0]   in_data = '0;
    logic [15:0]   p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic          win_valid;
    logic [XW-1:0] win_cx;
    logic [YW-1:0] win_cy;

    window3x3_gen #(.H_ACT(H), .V_ACT(V), .DATA_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_data      (in_data),
        .PixelData_00 (p00),
        .PixelData_01 (p01),
        .PixelData_02 (p02),
        .PixelData_10 (p10),
        .PixelData_11 (p11),
        .PixelData_12 (p12),
        .PixelData_20 (p20),
        .PixelData_21 (p21),
        .PixelData_22 (p22),
        .win_valid    (win_valid),
        .win_cx       (win_cx),
        .win_cy       (win_cy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pix [9];
        int          cx;
        int          cy;
    } win_t;

    win_t        exp_q [$];
    logic [15:0] dpix [9];
    logic [15:0] hist [H][3];
    int          mx = 0;
    int          my = 0;
    int          acc_total = 0;
    int          cap_cnt = 0;
    logic        cap_v = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          win_cnt = 0;
    logic        chk_first = 1'b0;
    logic        chk_wrap = 1'b0;
    logic        chk_rst = 1'b0;

    assign dpix[0] = p00;
    assign dpix[1] = p01;
    assign dpix[2] = p02;
    assign dpix[3] = p10;
    assign dpix[4] = p11;
    assign dpix[5] = p12;
    assign dpix[6] = p20;
    assign dpix[7] = p21;
    assign dpix[8] = p22;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: each column x remembers its last three pixels; a window is those histories for x-2..x.
    task automatic model_accept(input logic s, input logic [15:0] d);
        win_t e;
        int   x;
        int   y;
        if (s) begin
            mx = 0;
            my = 0;
        end
        x = mx;
        y = my;
        hist[x][0] = hist[x][1];
        hist[x][1] = hist[x][2];
        hist[x][2] = d;
        if (x >= 2 && y >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.pix[r*3+c] = hist[x-2+c][r];
            e.cx = x - 1;
            e.cy = y - 1;
            exp_q.push_back(e);
        end
        mx = (mx + 1) % H;
        if (mx == 0) my = (my + 1) % V;
        acc_total++;
    endtask

    task automatic step(input logic v, input logic s, input logic [15:0] d);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        if (v) model_accept(s, d);
    endtask

    // Pixel value {y,x} using the model's view of where the next pixel lands.
    task automatic pat(input logic s);
        logic [15:0] d;
        d = s ? 16'h0000 : 16'((my << 8) | mx);
        step(1'b1, s, d);
    endtask

    task automatic drain_and_count(input string name, input int exp_wins);
        step(1'b0, 1'b0, 16'(($urandom)));
        step(1'b0, 1'b0, 16'(($urandom)));
        chk({name, "_windows"}, win_cnt, exp_wins);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        win_cnt = 0;
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 9; i++) chk($sformatf("%s_pix%0d", tag, i), dpix[i], 0);
        chk({tag, "_valid"}, win_valid, 0);
        chk({tag, "_cx"}, win_cx, 0);
        chk({tag, "_cy"}, win_cy, 0);
    endtask

    always @(posedge clk) begin
        cap_v   <= in_valid;
        cap_cnt <= acc_total;
    end

    // Monitor: every window the DUT presents is popped from the scoreboard and compared.
    always @(negedge clk) begin
        win_t e;
        if (win_valid) begin
            win_cnt++;
            chk("win_follows_accept", cap_v, 1);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_window: cx=%0d cy=%0d, no window expected", win_cx, win_cy);
            end else begin
                e = exp_q.pop_front();
                chk("win_cx", win_cx, e.cx);
                chk("win_cy", win_cy, e.cy);
                for (int i = 0; i < 9; i++) chk($sformatf("pix%0d", i), dpix[i], e.pix[i]);
            end
            if (chk_first) begin
                chk("first_cx", win_cx, 1);
                chk("first_cy", win_cy, 1);
                chk("first_p00", p00, 16'h0000);
                chk("first_p11", p11, 16'h0101);
                chk("first_p22", p22, 16'h0202);
                chk_first = 1'b0;
            end
            if (chk_wrap && win_cx == 1 && win_cy == 2) begin
                chk("wrap_p20", p20, 16'h0300);
                chk("wrap_p02", p02, 16'h0102);
                chk_wrap = 1'b0;
            end
            if (chk_rst) begin
                chk("rst_first_win_after_pixels", cap_cnt, 19);
                chk_rst = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int x = 0; x < H; x++)
            for (int k = 0; k < 3; k++) hist[x][k] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        // Full frame, continuous valid, sof on first pixel; also the row-wrap window.
        chk_first = 1'b1;
        chk_wrap  = 1'b1;
        for (int i = 0; i < H*V; i++) pat(i == 0);
        drain_and_count("t1_full", 24);
        chk("t1_first_seen", chk_first, 0);
        chk("t2_wrap_seen", chk_wrap, 0);

        // Valid toggling every cycle.
        chk_first = 1'b1;
        for (int i = 0; i < H*V; i++) begin
            pat(i == 0);
            step(1'b0, 1'b0, 16'($urandom));
        end
        drain_and_count("t3_toggle", 24);
        chk("t3_first_seen", chk_first, 0);

        // sof in mid-frame at (5,4) restarts the counters.
        for (int i = 0; i < 37; i++) pat(i == 0);
        pat(1'b1);
        pat(1'b0);
        chk_first = 1'b1;
        for (int i = 2; i < H*V; i++) pat(1'b0);
        drain_and_count("t4_midsof", 39);
        chk("t4_first_seen", chk_first, 0);

        // Two frames back-to-back, sof only on the first.
        for (int i = 0; i < H*V; i++) pat(i == 0);
        pat(1'b0);
        pat(1'b0);
        chk_first = 1'b1;
        for (int i = 2; i < H*V; i++) pat(1'b0);
        drain_and_count("t5_b2b", 48);
        chk("t5_first_seen", chk_first, 0);

        // Reset mid-line after pixel (3,3); outputs clear without a clock edge.
        for (int i = 0; i < 28; i++) pat(i == 0);
        drain_and_count("t6_pre", 8);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        mx = 0;
        my = 0;
        acc_total = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_rst   = 1'b1;
        chk_first = 1'b1;
        for (int i = 0; i < H*V; i++) pat(1'b0);
        drain_and_count("t6_post", 24);
        chk("t6_first_seen", chk_first, 0);
        chk("t6_rst_seen", chk_rst, 0);

        // Random data with random gaps over two frames.
        for (int n = 0; n < 2*H*V; ) begin
            if ($urandom_range(0, 9) < 7) begin
                step(1'b1, n == 0, 16'($urandom));
                n++;
            end else begin
                step(1'b0, 1'b0, 16'($urandom));
            end
        end
        drain_and_count("t7_random", 48);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
